mem_port_arbiter: RTL and testbench

- Shares the single memory/writebuffer port between the fetch requester (instruction) and the execute-stage load/store/fence requester (data).
- Data requests normally win; a starvation counter forces an instruction grant after a bounded run of data grants.
- One outstanding transaction at a time, request/ready level handshake matching mem_ready usage in the pipeline.
- Supports fetch flush: an in-flight instruction response is swallowed.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between the fetch (instruction) and execute (data) requesters.
// Data normally wins; a bounded streak of data grants forces a waiting fetch through.
module mem_port_arbiter #(
  parameter int DBURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] DMAX = 4'(DBURST_MAX);

  state_t     state;
  state_t     state_next;
  logic [3:0] dstreak;
  logic       drop;
  logic       grant_d;
  logic       grant_i;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    state_next = state;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    case (state)
      IDLE: begin
        grant_d = d_valid && (!i_valid || (dstreak < DMAX));
        grant_i = !grant_d && i_valid && !i_flush;
        if (grant_d)      state_next = BUSY_D;
        else if (grant_i) state_next = BUSY_I;
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_next = IDLE;
          i_ready    = !drop && !i_flush;
          i_rdata    = (!drop && !i_flush) ? mem_rdata : '0;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_next = IDLE;
          d_ready    = 1'b1;
          d_rdata    = mem_rdata;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory request registers are loaded only at grant, so they stay stable for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (grant_d) begin
      mem_valid <= 1'b1;
      mem_instr <= 1'b0;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_wstrb <= d_wstrb;
    end else if (grant_i) begin
      mem_valid <= 1'b1;
      mem_instr <= 1'b1;
      mem_addr  <= i_addr;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if ((state != IDLE) && mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

  // The streak only counts data grants that actually made a fetch wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      dstreak <= '0;
    end else if (state == IDLE) begin
      if (grant_d && i_valid)
        dstreak <= (dstreak < DMAX) ? dstreak + 4'd1 : DMAX;
      else if (grant_i || !i_valid)
        dstreak <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (state == BUSY_I) begin
      if (mem_ready)    drop <= 1'b0;
      else if (i_flush) drop <= 1'b1;
    end else begin
      drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int DBURST_MAX = 4;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int vectors;
  int miscompares;

  mem_port_arbiter #(.DBURST_MAX(DBURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_flush(i_flush), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    i_valid = 0; i_addr = 0; i_flush = 0;
    d_valid = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; d_valid = 1; d_addr = 32'hFFFF_0000; d_wdata = 32'hAAAA_5555; d_wstrb = 4'hF;
    i_valid = 1; i_addr = 32'h1234_0000; i_flush = 0; mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_valid: got %h want 0", mem_valid); end
    vectors++; if (mem_instr !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_instr: got %h want 0", mem_instr); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mem_addr: got %h want 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    vectors++; if (mem_wstrb !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_mem_wstrb: got %h want 0", mem_wstrb); end
    vectors++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ready: got i=%h d=%h want 0 0", i_ready, d_ready); end
    do_reset();
  endtask

  task automatic test_data_read();
    do_reset();
    d_valid = 1; d_addr = 32'h0000_1000; d_wstrb = 4'h0; d_wdata = 32'h5A5A_0001;
    @(negedge clk);
    vectors++; if (mem_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_mem_valid: got %h want 1", mem_valid); end
    vectors++; if (mem_instr !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_mem_instr: got %h want 0", mem_instr); end
    vectors++; if (mem_addr !== 32'h0000_1000) begin miscompares++; $display("[TB] FAIL rd_mem_addr: got %h want 00001000", mem_addr); end
    vectors++; if (mem_wstrb !== 4'h0) begin miscompares++; $display("[TB] FAIL rd_mem_wstrb: got %h want 0", mem_wstrb); end
    for (int w = 0; w < 2; w++) begin
      vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_early_ready: got %h want 0", d_ready); end
      @(negedge clk);
    end
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_d_ready: got %h want 1", d_ready); end
    vectors++; if (d_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd_d_rdata: got %h want deadbeef", d_rdata); end
    vectors++; if (i_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_i_ready: got %h want 0", i_ready); end
    @(negedge clk);
    mem_ready = 0; d_valid = 0;
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_mem_valid_clear: got %h want 0", mem_valid); end
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_d_ready_pulse: got %h want 0", d_ready); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_valid = 1; i_addr = 32'h0000_2000;
    d_valid = 1; d_addr = 32'h0000_3000; d_wdata = 32'h1111_2222; d_wstrb = 4'h3;
    @(negedge clk);
    vectors++; if (mem_instr !== 1'b0 || mem_addr !== 32'h0000_3000) begin miscompares++; $display("[TB] FAIL sim_first: got instr=%h addr=%h want 0 00003000", mem_instr, mem_addr); end
    mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    #1;
    vectors++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL sim_first_ready: got d=%h i=%h want 1 0", d_ready, i_ready); end
    @(negedge clk);
    mem_ready = 0; d_valid = 0;
    @(negedge clk);
    vectors++; if (mem_valid !== 1'b1 || mem_instr !== 1'b1) begin miscompares++; $display("[TB] FAIL sim_second_grant: got valid=%h instr=%h want 1 1", mem_valid, mem_instr); end
    vectors++; if (mem_addr !== 32'h0000_2000) begin miscompares++; $display("[TB] FAIL sim_second_addr: got %h want 00002000", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin miscompares++; $display("[TB] FAIL sim_second_wr: got wdata=%h wstrb=%h want 0 0", mem_wdata, mem_wstrb); end
    mem_ready = 1; mem_rdata = 32'h1357_9BDF;
    #1;
    vectors++; if (i_ready !== 1'b1 || i_rdata !== 32'h1357_9BDF || d_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL sim_second_ready: got i=%h rdata=%h d=%h want 1 13579bdf 0", i_ready, i_rdata, d_ready); end
    @(negedge clk);
    mem_ready = 0; i_valid = 0;
  endtask

  task automatic test_starvation();
    logic [31:0] exp_d;
    logic        exp_instr;
    do_reset();
    i_valid = 1; i_addr = 32'h0000_4000;
    exp_d = 32'h0000_5000;
    d_valid = 1; d_addr = exp_d; d_wstrb = 4'h0; d_wdata = 32'h0;
    for (int k = 0; k <= DBURST_MAX + 1; k++) begin
      @(negedge clk);
      exp_instr = (k == DBURST_MAX);
      vectors++; if (mem_valid !== 1'b1 || mem_instr !== exp_instr) begin miscompares++; $display("[TB] FAIL starve_grant%0d: got valid=%h instr=%h want 1 %h", k, mem_valid, mem_instr, exp_instr); end
      vectors++; if (mem_addr !== (exp_instr ? 32'h0000_4000 : exp_d)) begin miscompares++; $display("[TB] FAIL starve_addr%0d: got %h want %h", k, mem_addr, exp_instr ? 32'h0000_4000 : exp_d); end
      mem_ready = 1; mem_rdata = $urandom;
      #1;
      vectors++; if (i_ready !== exp_instr || d_ready !== !exp_instr) begin miscompares++; $display("[TB] FAIL starve_ready%0d: got i=%h d=%h want %h %h", k, i_ready, d_ready, exp_instr, !exp_instr); end
      @(negedge clk);
      mem_ready = 0;
      if (!exp_instr) exp_d = exp_d + 32'd4;
      d_addr = exp_d;
    end
    i_valid = 0; d_valid = 0;
  endtask

  task automatic test_flush();
    do_reset();
    i_valid = 1; i_addr = 32'h0000_6000;
    @(negedge clk);
    vectors++; if (mem_valid !== 1'b1 || mem_instr !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_grant: got valid=%h instr=%h want 1 1", mem_valid, mem_instr); end
    i_flush = 1; i_valid = 0;
    @(negedge clk);
    i_flush = 0; mem_ready = 1; mem_rdata = 32'hFEED_FACE;
    #1;
    vectors++; if (mem_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_not_aborted: got %h want 1", mem_valid); end
    vectors++; if (i_ready !== 1'b0 || i_rdata !== 32'h0 || d_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_swallow: got i=%h rdata=%h d=%h want 0 0 0", i_ready, i_rdata, d_ready); end
    @(negedge clk);
    mem_ready = 0;
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_idle: got %h want 0", mem_valid); end
    d_valid = 1; d_addr = 32'h0000_7000; d_wstrb = 4'h0;
    @(negedge clk);
    vectors++; if (mem_valid !== 1'b1 || mem_instr !== 1'b0 || mem_addr !== 32'h0000_7000) begin miscompares++; $display("[TB] FAIL fl_next_data: got valid=%h instr=%h addr=%h want 1 0 00007000", mem_valid, mem_instr, mem_addr); end
    mem_ready = 1; mem_rdata = 32'h0000_0077;
    #1;
    vectors++; if (d_ready !== 1'b1 || d_rdata !== 32'h0000_0077) begin miscompares++; $display("[TB] FAIL fl_next_ready: got d=%h rdata=%h want 1 00000077", d_ready, d_rdata); end
    @(negedge clk);
    mem_ready = 0; d_valid = 0;
    // Flush landing on the same cycle as the response must also swallow it.
    i_valid = 1; i_addr = 32'h0000_6100;
    @(negedge clk);
    i_flush = 1; i_valid = 0; mem_ready = 1; mem_rdata = 32'h1234_4321;
    #1;
    vectors++; if (i_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_same_cycle: got %h want 0", i_ready); end
    @(negedge clk);
    mem_ready = 0;
    // A flush in IDLE blocks the fetch grant that cycle.
    i_valid = 1; i_addr = 32'h0000_6200; i_flush = 1;
    @(negedge clk);
    vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_idle_block: got %h want 0", mem_valid); end
    i_flush = 0; i_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_store();
    do_reset();
    d_valid = 1; d_addr = 32'h0000_8000; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    @(negedge clk);
    d_addr = 32'hFFFF_FFF0; d_wdata = 32'h0; d_wstrb = 4'h1;
    for (int w = 0; w < 5; w++) begin
      vectors++; if (mem_valid !== 1'b1 || mem_wstrb !== 4'hF || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h0000_8000)
        begin miscompares++; $display("[TB] FAIL st_hold%0d: got valid=%h wstrb=%h wdata=%h addr=%h want 1 f 12345678 00008000", w, mem_valid, mem_wstrb, mem_wdata, mem_addr); end
      vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL st_early%0d: got %h want 0", w, d_ready); end
      @(negedge clk);
    end
    mem_ready = 1; mem_rdata = 32'h0000_00A5;
    #1;
    vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL st_ready: got %h want 1", d_ready); end
    @(negedge clk);
    mem_ready = 0; d_valid = 0;
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL st_pulse: got %h want 0", d_ready); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    d_valid = 1; d_addr = 32'h0000_9000; d_wdata = 32'h9999_0000; d_wstrb = 4'hC;
    @(negedge clk);
    vectors++; if (mem_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_busy: got %h want 1", mem_valid); end
    rst = 1; d_valid = 0;
    @(negedge clk);
    vectors++; if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 || mem_instr !== 1'b0)
      begin miscompares++; $display("[TB] FAIL rm_outputs: got valid=%h addr=%h wdata=%h wstrb=%h instr=%h want all 0", mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_instr); end
    rst = 0;
    @(negedge clk);
    mem_ready = 1; mem_rdata = 32'h7777_7777;
    #1;
    vectors++; if (d_ready !== 1'b0 || i_ready !== 1'b0 || mem_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_ignore: got d=%h i=%h valid=%h want 0 0 0", d_ready, i_ready, mem_valid); end
    @(negedge clk);
    mem_ready = 0;
  endtask

  task automatic test_random();
    int          streak;
    bit          i_pend;
    bit          d_pend;
    bit          win_d;
    int          waits;
    logic [31:0] ea;
    logic [31:0] ew;
    logic [3:0]  es;
    logic [31:0] rd;
    do_reset();
    streak = 0; i_pend = 0; d_pend = 0;
    for (int t = 0; t < 300; t++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin i_pend = 1; i_addr = $urandom & 32'hFFFF_FFFC; end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1; d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
      end
      if (!i_pend && !d_pend) begin
        d_pend = 1; d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
      end
      i_valid = i_pend; d_valid = d_pend;
      mem_ready = $urandom_range(0, 1) == 1; mem_rdata = $urandom;
      #1;
      vectors++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_idle_ready%0d: got i=%h d=%h want 0 0", t, i_ready, d_ready); end
      // Data wins unless a waiting fetch has already sat through DBURST_MAX data grants.
      win_d = d_pend && (!i_pend || streak < DBURST_MAX);
      if (win_d && i_pend) streak = (streak < DBURST_MAX) ? streak + 1 : streak;
      else                 streak = 0;
      ea = win_d ? d_addr : i_addr;
      ew = win_d ? d_wdata : 32'h0;
      es = win_d ? d_wstrb : 4'h0;
      @(negedge clk);
      mem_ready = 0;
      vectors++; if (mem_valid !== 1'b1 || mem_instr !== !win_d) begin miscompares++; $display("[TB] FAIL rnd_grant%0d: got valid=%h instr=%h want 1 %h", t, mem_valid, mem_instr, !win_d); end
      vectors++; if (mem_addr !== ea || mem_wdata !== ew || mem_wstrb !== es)
        begin miscompares++; $display("[TB] FAIL rnd_req%0d: got addr=%h wdata=%h wstrb=%h want %h %h %h", t, mem_addr, mem_wdata, mem_wstrb, ea, ew, es); end
      waits = $urandom_range(0, 3);
      for (int w = 0; w < waits; w++) begin
        #1;
        vectors++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_wait%0d: got i=%h d=%h want 0 0", t, i_ready, d_ready); end
        @(negedge clk);
        vectors++; if (mem_valid !== 1'b1 || mem_addr !== ea) begin miscompares++; $display("[TB] FAIL rnd_stable%0d: got valid=%h addr=%h want 1 %h", t, mem_valid, mem_addr, ea); end
      end
      rd = $urandom;
      mem_ready = 1; mem_rdata = rd;
      #1;
      vectors++; if (d_ready !== win_d || i_ready !== !win_d) begin miscompares++; $display("[TB] FAIL rnd_ready%0d: got d=%h i=%h want %h %h", t, d_ready, i_ready, win_d, !win_d); end
      vectors++; if (d_rdata !== (win_d ? rd : 32'h0) || i_rdata !== (win_d ? 32'h0 : rd))
        begin miscompares++; $display("[TB] FAIL rnd_rdata%0d: got d=%h i=%h want %h %h", t, d_rdata, i_rdata, win_d ? rd : 32'h0, win_d ? 32'h0 : rd); end
      @(negedge clk);
      mem_ready = 0;
      if (win_d) d_pend = 0;
      else       i_pend = 0;
    end
    i_valid = 0; d_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1;
    i_valid = 0; i_addr = 0; i_flush = 0;
    d_valid = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    @(negedge clk);
    test_reset();
    test_data_read();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
